// File: rtl/switch_control_param_if.sv
// Bus bundle for switch_control_param: header requests/grants, flits and crossbar selects.
// The master side drives requests and flits; the switch controller is the slave.
interface switch_control_param_if #(
  parameter int COORD_W = 4,
  parameter int FLIT_W  = 16
);
  logic [4:0]           h;
  logic [4:0]           ack_h;
  logic [2*COORD_W-1:0] address;
  logic [5*FLIT_W-1:0]  data;
  logic [4:0]           sender;
  logic [4:0]           free;
  logic [14:0]          mux_in;
  logic [14:0]          mux_out;

  modport master (
    output h, address, data, sender,
    input  ack_h, free, mux_in, mux_out
  );

  modport slave (
    input  h, address, data, sender,
    output ack_h, free, mux_in, mux_out
  );
endinterface

// File: rtl/switch_control_param.sv
// switch_control_param: 5-port round-robin crossbar controller with dimension-order routing.
// Define SC_YX_ROUTING_EN to resolve the Y coordinate before X (YX); default build routes XY.
module switch_control_param #(
  parameter int COORD_W = 4,
  parameter int FLIT_W  = 16
) (
  input logic                   clock,
  input logic                   reset,
  switch_control_param_if.slave bus
);
  localparam int NPORT = 5;

  localparam logic [2:0] LOCAL = 3'd0;
  localparam logic [2:0] EAST  = 3'd1;
  localparam logic [2:0] WEST  = 3'd2;
  localparam logic [2:0] NORTH = 3'd3;
  localparam logic [2:0] SOUTH = 3'd4;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ARB   = 3'd2;
  localparam logic [2:0] S_ROUTE = 3'd3;
  localparam logic [2:0] S_GRANT = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [2:0]           sel_q, out_q, lastSel_q;
  logic [2*COORD_W-1:0] hdr_q;
  logic [4:0]           ack_q, free_q, free_d, senderDly_q;
  logic [14:0]          muxIn_q, muxOut_q;

  logic [2:0]           rrSel, cand, routeOut;
  logic [2*COORD_W-1:0] hdrPick;
  logic [COORD_W-1:0]   tx, ty, myX, myY;

  function automatic logic [2:0] wrapPort(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  // Scan downwards so the nearest requester after lastSel_q is the one that sticks.
  always_comb begin
    rrSel = wrapPort({1'b0, lastSel_q} + 4'd1);
    cand  = LOCAL;
    for (int k = NPORT; k >= 1; k--) begin
      cand = wrapPort({1'b0, lastSel_q} + 4'(k));
      if (bus.h[cand]) rrSel = cand;
    end
  end

  // Only the coordinate field of the header flit matters for routing, so only it is kept.
  assign hdrPick = bus.data[int'(rrSel)*FLIT_W + FLIT_W - 2*COORD_W +: 2*COORD_W];

  assign tx  = hdr_q[2*COORD_W-1 -: COORD_W];
  assign ty  = hdr_q[COORD_W-1:0];
  assign myX = bus.address[2*COORD_W-1 -: COORD_W];
  assign myY = bus.address[COORD_W-1:0];

  always_comb begin
    routeOut = LOCAL;
`ifdef SC_YX_ROUTING_EN
    if (ty > myY)      routeOut = SOUTH;
    else if (ty < myY) routeOut = NORTH;
    else if (tx > myX) routeOut = EAST;
    else if (tx < myX) routeOut = WEST;
`else
    if (tx > myX)      routeOut = EAST;
    else if (tx < myX) routeOut = WEST;
    else if (ty > myY) routeOut = SOUTH;
    else if (ty < myY) routeOut = NORTH;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_IDLE;
      S_IDLE:  if (|bus.h) state_d = S_ARB;
      S_ARB:   state_d = S_ROUTE;
      S_ROUTE: state_d = (bus.h[sel_q] && free_q[routeOut]) ? S_GRANT : S_IDLE;
      S_GRANT: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Releases are applied first so that a grant to the same output at this edge wins.
  always_comb begin
    free_d = free_q;
    for (int i = 0; i < NPORT; i++) begin
      if (senderDly_q[i] && !bus.sender[i]) free_d[muxIn_q[3*i +: 3]] = 1'b1;
    end
    if (state_q == S_GRANT) free_d[out_q] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INIT;
      sel_q       <= LOCAL;
      out_q       <= LOCAL;
      lastSel_q   <= LOCAL;
      hdr_q       <= '0;
      ack_q       <= '0;
      free_q      <= 5'b11111;
      senderDly_q <= '0;
      muxIn_q     <= '0;
      muxOut_q    <= '0;
    end else begin
      state_q     <= state_d;
      free_q      <= free_d;
      senderDly_q <= bus.sender;
      ack_q       <= '0;
      if (state_q == S_ARB) begin
        sel_q     <= rrSel;
        lastSel_q <= rrSel;
        hdr_q     <= hdrPick;
      end
      if (state_q == S_ROUTE) out_q <= routeOut;
      if (state_q == S_GRANT) begin
        muxIn_q[3*sel_q +: 3]  <= out_q;
        muxOut_q[3*out_q +: 3] <= sel_q;
        ack_q[sel_q]           <= 1'b1;
      end
    end
  end

  assign bus.ack_h   = ack_q;
  assign bus.free    = free_q;
  assign bus.mux_in  = muxIn_q;
  assign bus.mux_out = muxOut_q;
endmodule

// File: tb/tb_switch_control_param.sv
// Bench for switch_control_param: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_switch_control_param;
  localparam int COORD_W = 4;
  localparam int FLIT_W  = 16;
  localparam int NP      = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  switch_control_param_if #(.COORD_W(COORD_W), .FLIT_W(FLIT_W)) bus ();

  switch_control_param #(.COORD_W(COORD_W), .FLIT_W(FLIT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int passes = 0;
  bit cmpEn  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference model: free map, crossbar tables and a round timeline, updated per edge.
  logic [4:0]           mFree, mAck, mSenderPrev, mFreeOld;
  int                   mMuxIn[NP];
  int                   mMuxOut[NP];
  int                   mNextRr, mAge, mSel, mOut;
  bit                   mStartup;
  logic [2*COORD_W-1:0] mHdr;

  function automatic int routeOf(input logic [2*COORD_W-1:0] dest, input logic [2*COORD_W-1:0] here);
    int dx, dy;
    dx = int'(dest[2*COORD_W-1:COORD_W]) - int'(here[2*COORD_W-1:COORD_W]);
    dy = int'(dest[COORD_W-1:0]) - int'(here[COORD_W-1:0]);
`ifdef SC_YX_ROUTING_EN
    if (dy > 0) return 4;
    if (dy < 0) return 3;
    if (dx > 0) return 1;
    if (dx < 0) return 2;
`else
    if (dx > 0) return 1;
    if (dx < 0) return 2;
    if (dy > 0) return 4;
    if (dy < 0) return 3;
`endif
    return 0;
  endfunction

  function automatic logic [14:0] packMux(input int a[NP]);
    logic [14:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[3*i +: 3] = 3'(a[i]);
    return r;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mFree       = 5'b11111;
      mAck        = '0;
      mSenderPrev = '0;
      mNextRr     = 1;
      mAge        = -1;
      mStartup    = 1'b1;
      mSel        = 0;
      mOut        = 0;
      mHdr        = '0;
      for (int i = 0; i < NP; i++) begin
        mMuxIn[i]  = 0;
        mMuxOut[i] = 0;
      end
    end else begin
      mFreeOld = mFree;
      mAck     = '0;
      for (int i = 0; i < NP; i++)
        if (mSenderPrev[i] && !bus.sender[i]) mFree[mMuxIn[i]] = 1'b1;
      mSenderPrev = bus.sender;
      if (mStartup) mStartup = 1'b0;
      else if (mAge == -1) begin
        if (bus.h != 5'b0) mAge = 0;
      end else if (mAge == 0) begin
        mSel = mNextRr;
        for (int k = 0; k < NP; k++) begin
          if (bus.h[(mNextRr + k) % NP]) begin
            mSel = (mNextRr + k) % NP;
            break;
          end
        end
        mNextRr = (mSel + 1) % NP;
        mHdr    = bus.data[mSel*FLIT_W + FLIT_W - 1 -: 2*COORD_W];
        mAge    = 1;
      end else if (mAge == 1) begin
        mOut = routeOf(mHdr, bus.address);
        mAge = (bus.h[mSel] && mFreeOld[mOut]) ? 2 : -1;
      end else begin
        mMuxIn[mSel]  = mOut;
        mMuxOut[mOut] = mSel;
        mFree[mOut]   = 1'b0;
        mAck[mSel]    = 1'b1;
        mAge          = -1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmpEn) begin
      checkOutput("cmp_ack_h",   32'(bus.ack_h),   32'(mAck));
      checkOutput("cmp_free",    32'(bus.free),    32'(mFree));
      checkOutput("cmp_mux_in",  32'(bus.mux_in),  32'(packMux(mMuxIn)));
      checkOutput("cmp_mux_out", 32'(bus.mux_out), 32'(packMux(mMuxOut)));
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] hv, input logic [4:0] sv);
    bus.h      = hv;
    bus.sender = sv;
  endtask

  task automatic setFlit(input int port, input logic [FLIT_W-1:0] v);
    bus.data[port*FLIT_W +: FLIT_W] = v;
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(5'b0, 5'b0);
    bus.data = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic waitAck(input int bound, output int cycles, output logic [4:0] seen);
    cycles = 0;
    seen   = '0;
    while (cycles <= bound && seen == 5'b0) begin
      tick();
      cycles++;
      seen = bus.ack_h;
    end
  endtask

  task automatic randomPhase(input int ncycles);
    logic [4:0] hv, sv;
    int len[NP];
    hv = '0;
    sv = '0;
    for (int i = 0; i < NP; i++) len[i] = 0;
    for (int c = 0; c < ncycles; c++) begin
      tick();
      for (int i = 0; i < NP; i++) begin
        if (mAck[i]) begin
          hv[i]  = 1'b0;
          sv[i]  = 1'b1;
          len[i] = int'($urandom_range(1, 8));
        end else if (sv[i]) begin
          if (len[i] == 0) sv[i] = 1'b0;
          else len[i]--;
        end else if (!hv[i] && $urandom_range(0, 3) == 0) begin
          hv[i] = 1'b1;
        end
        setFlit(i, 16'($urandom));
      end
      applyStimulus(hv, sv);
    end
    applyStimulus(5'b0, 5'b0);
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         cyc;
    logic [4:0] seen;
    int         ackCount;
    logic [4:0] rrOrder[NP];
    logic [4:0] routedFree;
    logic [2:0] routedPort;

    rrOrder = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    bus.address = '0;
    bus.data    = '0;
    applyStimulus(5'b0, 5'b0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    cmpEn = 1'b1;

    // Reset state
    doReset();
    checkOutput("rst_free",    32'(bus.free),    32'h1F);
    checkOutput("rst_ack_h",   32'(bus.ack_h),   32'h0);
    checkOutput("rst_mux_in",  32'(bus.mux_in),  32'h0);
    checkOutput("rst_mux_out", 32'(bus.mux_out), 32'h0);

    // Local delivery from EAST
    bus.address = 8'h22;
    setFlit(1, 16'h22AB);
    applyStimulus(5'b00010, 5'b0);
    waitAck(10, cyc, seen);
    checkOutput("local_latency", 32'(cyc), 32'd4);
    checkOutput("local_ack_h",   32'(seen), 32'h02);
    checkOutput("local_mux_out0", 32'(bus.mux_out[2:0]), 32'd1);
    checkOutput("local_mux_in1",  32'(bus.mux_in[5:3]),  32'd0);
    checkOutput("local_free",    32'(bus.free), 32'h1E);
    applyStimulus(5'b0, 5'b0);
    tick();
    checkOutput("local_ack_pulse", 32'(bus.ack_h), 32'h0);

    // XY versus YX dimension order
    doReset();
    bus.address = 8'h11;
    setFlit(0, 16'h33CD);
`ifdef SC_YX_ROUTING_EN
    routedFree = 5'b01111;
    routedPort = 3'd4;
`else
    routedFree = 5'b11101;
    routedPort = 3'd1;
`endif
    applyStimulus(5'b00001, 5'b0);
    waitAck(10, cyc, seen);
    checkOutput("route_ack_h",  32'(seen), 32'h01);
    checkOutput("route_free",   32'(bus.free), 32'(routedFree));
    checkOutput("route_mux_in", 32'(bus.mux_in[2:0]), 32'(routedPort));
    applyStimulus(5'b0, 5'b0);
    tick();

    // Round-robin with every input requesting a distinct output
    doReset();
    bus.address = 8'h22;
    setFlit(0, 16'h2200);
    setFlit(1, 16'h3200);
    setFlit(2, 16'h1200);
    setFlit(3, 16'h2100);
    setFlit(4, 16'h2300);
    applyStimulus(5'b11111, 5'b0);
    for (int k = 0; k < NP; k++) begin
      waitAck(10, cyc, seen);
      checkOutput($sformatf("rr_order%0d", k), 32'(seen), 32'(rrOrder[k]));
      checkOutput($sformatf("rr_gap%0d", k),   32'(cyc),  32'd4);
    end
    checkOutput("rr_free_all_taken", 32'(bus.free), 32'h00);
    applyStimulus(5'b0, 5'b0);
    tick();

    // Busy output, then release and retry
    doReset();
    bus.address = 8'h22;
    setFlit(2, 16'h3200);
    applyStimulus(5'b00100, 5'b0);
    waitAck(10, cyc, seen);
    checkOutput("busy_first_ack", 32'(seen), 32'h04);
    setFlit(0, 16'h3200);
    applyStimulus(5'b00001, 5'b00100);
    ackCount = 0;
    repeat (12) begin
      tick();
      if (bus.ack_h != 5'b0) ackCount++;
    end
    checkOutput("busy_no_ack", 32'(ackCount), 32'd0);
    checkOutput("busy_free",   32'(bus.free), 32'h1D);
    applyStimulus(5'b00001, 5'b00000);
    tick();
    checkOutput("release_free", 32'(bus.free), 32'h1F);
    waitAck(8, cyc, seen);
    checkOutput("retry_ack_h",   32'(seen), 32'h01);
    checkOutput("retry_free",    32'(bus.free), 32'h1D);
    checkOutput("retry_mux_in0", 32'(bus.mux_in[2:0]),  32'd1);
    checkOutput("retry_mux_out1", 32'(bus.mux_out[5:3]), 32'd0);
    applyStimulus(5'b0, 5'b0);
    tick();

    // Reset pulled while a request sits in ROUTE
    doReset();
    bus.address = 8'h22;
    setFlit(1, 16'h22AB);
    applyStimulus(5'b00010, 5'b0);
    waitAck(10, cyc, seen);
    checkOutput("midrst_pre_ack", 32'(seen), 32'h02);
    setFlit(2, 16'h3200);
    applyStimulus(5'b00100, 5'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midrst_free",    32'(bus.free),    32'h1F);
    checkOutput("midrst_ack_h",   32'(bus.ack_h),   32'h0);
    checkOutput("midrst_mux_out", 32'(bus.mux_out), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    waitAck(12, cyc, seen);
    checkOutput("midrst_latency", 32'(cyc),  32'd5);
    checkOutput("midrst_ack_h2",  32'(seen), 32'h04);
    checkOutput("midrst_free2",   32'(bus.free), 32'h1D);
    checkOutput("midrst_mux_in2", 32'(bus.mux_in[8:6]), 32'd1);
    applyStimulus(5'b0, 5'b0);
    tick();

    // Randomized traffic against the reference model
    for (int p = 0; p < 2; p++) begin
      doReset();
      bus.address = 8'($urandom);
      randomPhase(600);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
